// File: rtl/pattern_link_pkg.sv
// Shared definitions for the 256-bit serial pattern-match link (encoder and decoder).
package pattern_link_pkg;

    localparam int WIDTH_DEFAULT = 256;

    // Counter width able to hold 0..width inclusive.
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ARMED = 2'd1,
        SEND  = 2'd2
    } state_t;

endpackage

// File: rtl/pattern_loader.sv
// Serial-in parallel-out pattern store; first bit shifted in ends up at pattern[WIDTH-1].
module pattern_loader
    import pattern_link_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             prgm,
    input  logic             enable,
    output logic [WIDTH-1:0] pattern,
    output logic             full,
    output logic             last
);

    logic [CNT_W-1:0] load_cnt;
    logic             shift;

    // Once full the store is frozen until clr, so a stray enable can never corrupt it.
    assign full  = (load_cnt == CNT_W'(WIDTH));
    assign shift = enable && !full;
    assign last  = shift && (load_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (clr) begin
            pattern  <= '0;
            load_cnt <= '0;
        end else if (shift) begin
            pattern  <= {pattern[WIDTH-2:0], prgm};
            load_cnt <= load_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pattern_encoder256.sv
// Serial pattern transmitter: loads a WIDTH-bit pattern bit-serially, then replays it MSB-first on sig.
module pattern_encoder256
    import pattern_link_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic clk,
    input  logic clr,
    input  logic prgm,
    input  logic enable,
    input  logic start,
    input  logic repeat_en,
    output logic sig,
    output logic busy,
    output logic ready,
    output logic done
);

    localparam int IDX_W = CNT_W - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state;
    logic [IDX_W-1:0] tx_idx;
    logic [WIDTH-1:0] pattern;
    logic             full;
    logic             last;

    pattern_loader #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_loader (
        .clk     (clk),
        .clr     (clr),
        .prgm    (prgm),
        .enable  (enable),
        .pattern (pattern),
        .full    (full),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= LOAD;
            tx_idx <= '0;
            sig    <= 1'b0;
            busy   <= 1'b0;
            ready  <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    sig  <= 1'b0;
                    busy <= 1'b0;
                    done <= 1'b0;
                    // Arm on the same edge that samples the final bit.
                    if (last) begin
                        state <= ARMED;
                        ready <= 1'b1;
                    end else begin
                        ready <= 1'b0;
                    end
                end
                ARMED: begin
                    sig  <= 1'b0;
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start && full) begin
                        state  <= SEND;
                        tx_idx <= LAST_IDX;
                        ready  <= 1'b0;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                SEND: begin
                    sig   <= pattern[tx_idx];
                    busy  <= 1'b1;
                    ready <= 1'b0;
                    // repeat_en only matters at the last bit; wrapping keeps the stream gap-free.
                    if (tx_idx == '0) begin
                        if (repeat_en) begin
                            tx_idx <= LAST_IDX;
                            done   <= 1'b0;
                        end else begin
                            state <= ARMED;
                            done  <= 1'b1;
                        end
                    end else begin
                        tx_idx <= tx_idx - IDX_W'(1);
                        done   <= 1'b0;
                    end
                end
                default: begin
                    state  <= LOAD;
                    tx_idx <= '0;
                    sig    <= 1'b0;
                    busy   <= 1'b0;
                    ready  <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule
